// File: rtl/ntr_cmd_sequencer.sv
// rtl/ntr_cmd_sequencer.sv - NTR slave bus command framer and response strobe sequencer
module ntr_cmd_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ntr_clk,
    input  logic             ntr_cs1,
    input  logic [7:0]       ntr_data,
    output logic [63:0]      cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             resp_strobe,
    output logic [IDX_W-1:0] resp_index,
    output logic             xfer_active,
    output logic             overrun,
    output logic             abort,
    output logic [3:0]       led
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CMD      = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [7:0]             data_sync [SYNC_STAGES];

    logic             clk_s;
    logic             cs_s;
    logic [7:0]       data_s;
    logic             clk_prev;
    logic             cs_prev;
    logic             ntr_edge;
    logic             cs_fall;
    logic             cs_rise;
    logic             handshake;
    logic [1:0]       state;
    logic [2:0]       byte_cnt;
    logic [IDX_W-1:0] resp_ptr;

    // All three bus inputs share one depth so data stays aligned with its clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= '0;
            cs_sync  <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= 8'h00;
            end
        end else begin
            clk_sync     <= {clk_sync[SYNC_STAGES-2:0], ntr_clk};
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], ntr_cs1};
            data_sync[0] <= ntr_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_prev <= 1'b0;
            cs_prev  <= 1'b1;
        end else begin
            clk_prev <= clk_s;
            cs_prev  <= cs_s;
        end
    end

    assign ntr_edge  = clk_s & ~clk_prev & ~cs_s;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign handshake = cmd_valid & cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_data    <= 64'h0;
            cmd_valid   <= 1'b0;
            resp_strobe <= 1'b0;
            resp_index  <= '0;
            resp_ptr    <= '0;
            byte_cnt    <= 3'd0;
            overrun     <= 1'b0;
            abort       <= 1'b0;
        end else begin
            resp_strobe <= 1'b0;
            // A pending command may be accepted in any state, even after the frame ended.
            if (handshake) begin
                cmd_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        if (cmd_valid) begin
                            overrun <= 1'b1;
                        end else begin
                            state      <= ST_CMD;
                            byte_cnt   <= 3'd0;
                            resp_ptr   <= '0;
                            resp_index <= '0;
                            overrun    <= 1'b0;
                            abort      <= 1'b0;
                        end
                    end
                end
                ST_CMD: begin
                    if (cs_rise) begin
                        abort <= 1'b1;
                        state <= ST_IDLE;
                    end else if (ntr_edge) begin
                        cmd_data <= {cmd_data[55:0], data_s};
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd7) begin
                            cmd_valid <= 1'b1;
                            state     <= ST_WAIT_ACK;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end else begin
                        // An edge in the acceptance cycle is still too early to be word 0.
                        if (ntr_edge) begin
                            overrun <= 1'b1;
                        end
                        if (handshake) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end else if (ntr_edge) begin
                        resp_strobe <= 1'b1;
                        resp_index  <= resp_ptr;
                        resp_ptr    <= resp_ptr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign xfer_active = ~cs_s;
    assign led         = {abort, overrun, cmd_valid, xfer_active};

endmodule

// File: tb/tb_ntr_cmd_sequencer.sv
// tb/tb_ntr_cmd_sequencer.sv - directed bench for ntr_cmd_sequencer
module tb_ntr_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        ntr_clk;
    logic        ntr_cs1;
    logic [7:0]  ntr_data;
    logic [63:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        resp_strobe;
    logic [12:0] resp_index;
    logic        xfer_active;
    logic        overrun;
    logic        abort;
    logic [3:0]  led;

    int total = 0;
    int bad   = 0;

    logic [12:0] idx_q [$];
    int          wide_cnt = 0;
    logic        strobe_prev = 1'b0;

    ntr_cmd_sequencer #(.SYNC_STAGES(2), .IDX_W(13)) dut (
        .clk         (clk),
        .rst         (rst),
        .ntr_clk     (ntr_clk),
        .ntr_cs1     (ntr_cs1),
        .ntr_data    (ntr_data),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .resp_strobe (resp_strobe),
        .resp_index  (resp_index),
        .xfer_active (xfer_active),
        .overrun     (overrun),
        .abort       (abort),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resp_strobe) begin
            idx_q.push_back(resp_index);
            if (strobe_prev) wide_cnt++;
        end
        strobe_prev = resp_strobe;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with ntr_clk low; returns at a negedge with ntr_clk low.
    task automatic ntr_byte(input logic [7:0] b);
        ntr_data = b;
        repeat (3) @(negedge clk);
        ntr_clk = 1'b1;
        repeat (3) @(negedge clk);
        ntr_clk = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] cmd, input bit ready_hi);
        for (int i = 0; i < 7; i++) begin
            ntr_byte(cmd[63-8*i -: 8]);
        end
        ntr_data = cmd[7:0];
        repeat (3) @(negedge clk);
        ntr_clk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 chk("valid_before_latency", cmd_valid, 1'b0);
        @(posedge clk);
        #1 chk("valid_at_latency", cmd_valid, 1'b1);
        chk("cmd_data", cmd_data, cmd);
        @(posedge clk);
        #1 chk("valid_next_cycle", cmd_valid, !ready_hi);
        repeat (2) @(negedge clk);
        ntr_clk = 1'b0;
    endtask

    initial begin
        int errs;
        rst       = 1'b1;
        ntr_clk   = 1'b0;
        ntr_cs1   = 1'b1;
        ntr_data  = 8'h00;
        cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_data", cmd_data, 64'h0);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_strobe", resp_strobe, 1'b0);
        chk("rst_index", resp_index, 13'h0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_abort", abort, 1'b0);
        chk("rst_xfer", xfer_active, 1'b0);
        chk("rst_led", led, 4'b0000);
        rst = 1'b0;

        // Reset asserted in the middle of a command
        @(negedge clk);
        ntr_cs1 = 1'b0;
        repeat (4) @(negedge clk);
        ntr_byte(8'h5A);
        ntr_byte(8'h5A);
        ntr_byte(8'h5A);
        repeat (3) @(negedge clk);
        chk("mid_cmd_data", cmd_data, 64'h5A5A5A);
        chk("mid_led", led, 4'b0001);
        rst = 1'b1;
        #1;
        chk("midrst_cmd_data", cmd_data, 64'h0);
        chk("midrst_led", led, 4'b0000);
        ntr_cs1 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_led", led, 4'b0000);

        // Basic frame, zero-wait acceptance
        ntr_cs1   = 1'b0;
        cmd_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("xfer_active_low_cs", xfer_active, 1'b1);
        send_frame(64'hFF00_0000_0000_0001, 1'b1);

        // Response phase
        idx_q.delete();
        wide_cnt = 0;
        for (int i = 0; i < 4; i++) ntr_byte(8'hC0 + 8'(i));
        repeat (3) @(negedge clk);
        chk("resp_count", idx_q.size(), 4);
        if (idx_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("resp_index_seq", idx_q[i], 13'(i));
        end
        chk("resp_strobe_width", wide_cnt, 0);
        ntr_cs1 = 1'b1;
        repeat (4) @(negedge clk);
        chk("resp_end_xfer", xfer_active, 1'b0);
        chk("resp_end_led", led, 4'b0000);

        // Abort after 5 bytes
        ntr_cs1 = 1'b0;
        repeat (4) @(negedge clk);
        ntr_byte(8'hA1);
        ntr_byte(8'hA2);
        ntr_byte(8'hA3);
        ntr_byte(8'hA4);
        ntr_byte(8'hA5);
        ntr_cs1 = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_flag", abort, 1'b1);
        chk("abort_valid", cmd_valid, 1'b0);
        chk("abort_led", led, 4'b1000);
        chk("abort_data_kept", cmd_data, 64'h0000_01A1_A2A3_A4A5);

        // Overrun while waiting for acceptance
        cmd_ready = 1'b0;
        ntr_cs1   = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_cleared", abort, 1'b0);
        send_frame(64'h1122_3344_5566_7788, 1'b0);
        idx_q.delete();
        ntr_byte(8'hE1);
        ntr_byte(8'hE2);
        repeat (3) @(negedge clk);
        chk("overrun_flag", overrun, 1'b1);
        chk("overrun_no_strobe", idx_q.size(), 0);
        chk("overrun_data_held", cmd_data, 64'h1122_3344_5566_7788);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("overrun_accept", cmd_valid, 1'b0);
        ntr_byte(8'hE3);
        repeat (3) @(negedge clk);
        chk("overrun_first_count", idx_q.size(), 1);
        if (idx_q.size() >= 1) chk("overrun_first_index", idx_q[0], 13'h0);
        chk("overrun_led", led, 4'b0101);

        // Response index wrap
        ntr_cs1 = 1'b1;
        repeat (4) @(negedge clk);
        ntr_cs1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("overrun_cleared", overrun, 1'b0);
        cmd_ready = 1'b1;
        send_frame(64'h0123_4567_89AB_CDEF, 1'b1);
        idx_q.delete();
        wide_cnt = 0;
        for (int i = 0; i < 32'h2001; i++) ntr_byte(8'(i));
        repeat (4) @(negedge clk);
        chk("wrap_count", idx_q.size(), 32'h2001);
        errs = 0;
        for (int i = 0; i < idx_q.size(); i++) begin
            if (idx_q[i] !== 13'(i)) errs++;
        end
        chk("wrap_seq_errors", errs, 0);
        if (idx_q.size() == 32'h2001) begin
            chk("wrap_top", idx_q[32'h1FFF], 13'h1FFF);
            chk("wrap_zero", idx_q[32'h2000], 13'h0);
        end
        chk("wrap_strobe_width", wide_cnt, 0);
        ntr_cs1 = 1'b1;
        repeat (4) @(negedge clk);
        chk("final_led", led, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
